// File: rtl/mips_seq_pkg.sv
// Shared encodings for the multicycle memory sequencer: FSM states, writeback
// source select codes and fault codes.
package mips_seq_pkg;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd2;
  localparam logic [2:0] ST_ADDM  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_ADDM = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_seq_timer.sv
// Memory wait counter: counts consecutive cycles a request is outstanding and
// flags the cycle in which the wait reaches TIMEOUT_CYCLES.
module mips_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_wait,
  output logic o_expire
);

  logic [15:0] r_count;

  // Any non-waiting cycle (ready, or no request) restarts the count, which
  // covers every entry into a requesting state.
  always_ff @(posedge i_clock) begin
    if (i_reset || !i_wait) begin
      r_count <= 16'd0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expire = i_wait && (r_count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_mem_sequencer.sv
// Multicycle control FSM sequencing a shared instruction/data memory around
// mips_decode. Define MIPS_SEQ_TIMEOUT_EN to build the memory-wait timeout.
module mips_mem_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        writeenable,
  input  logic        except,
  input  logic        mem_read,
  input  logic        word_we,
  input  logic        byte_we,
  input  logic        byte_load,
  input  logic        addm,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        addm_phase,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        pc_en,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [1:0]  r_fault;
  logic [1:0]  w_fault_next;
  logic [31:0] r_instret;
  logic        w_req;
  logic        w_ir_load;
  logic        w_mdr_load;
  logic        w_rf_we;
  logic        w_pc_en;
  logic        w_timeout;
  logic        w_is_store;
  logic        w_is_mem;

  assign w_is_store = word_we | byte_we;
  assign w_is_mem   = mem_read | w_is_store | addm;

`ifdef MIPS_SEQ_TIMEOUT_EN
  mips_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock (clock),
    .i_reset (reset),
    .i_wait  (w_req & ~mem_ready),
    .o_expire(w_timeout)
  );
`else
  logic [15:0] w_unused_limit;
  assign w_unused_limit = 16'(TIMEOUT_CYCLES);
  assign w_timeout      = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_fault_next = r_fault;
    w_req        = 1'b0;
    w_ir_load    = 1'b0;
    w_mdr_load   = 1'b0;
    w_rf_we      = 1'b0;
    w_pc_en      = 1'b0;
    mem_we       = 1'b0;
    mem_byte     = 1'b0;
    addr_sel     = 1'b0;
    addm_phase   = 1'b0;
    wb_sel       = WB_ALU;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_ir_load    = 1'b1;
          w_state_next = ST_EXEC;
        end else if (w_timeout) begin
          w_state_next = ST_HALT;
          w_fault_next = FAULT_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (except) begin
          w_state_next = ST_HALT;
          w_fault_next = FAULT_ILLEGAL;
        end else if (w_is_mem) begin
          w_state_next = ST_MEM;
        end else begin
          w_rf_we      = writeenable;
          w_pc_en      = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        w_req    = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        mem_byte = byte_we | byte_load;
        if (mem_ready) begin
          if (addm) begin
            w_mdr_load   = 1'b1;
            w_state_next = ST_ADDM;
          end else if (w_is_store) begin
            w_pc_en      = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_rf_we      = 1'b1;
            wb_sel       = WB_MEM;
            w_pc_en      = 1'b1;
            w_state_next = ST_FETCH;
          end
        end else if (w_timeout) begin
          w_state_next = ST_HALT;
          w_fault_next = FAULT_TIMEOUT;
        end
      end
      ST_ADDM: begin
        addm_phase   = 1'b1;
        wb_sel       = WB_ADDM;
        w_rf_we      = 1'b1;
        w_pc_en      = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // Reset suppresses every strobe, dropping any request in flight.
  assign mem_req  = w_req & ~reset;
  assign ir_load  = w_ir_load & ~reset;
  assign mdr_load = w_mdr_load & ~reset;
  assign rf_we    = w_rf_we & ~reset;
  assign pc_en    = w_pc_en & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_fault   <= FAULT_NONE;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_fault <= w_fault_next;
      if (w_pc_en) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign halted  = (r_state == ST_HALT);
  assign fault   = r_fault;
  assign instret = r_instret;
  assign state   = r_state;

endmodule
